// File: rtl/fact_accel_top_if.sv
// I/O-slot bus for the factorial accelerator: word address, write strobe/data,
// combinational read data and the level done indication.
interface fact_accel_top_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2:0]            A;
  logic                  WE;
  logic [DATA_WIDTH-1:0] WD;
  logic [DATA_WIDTH-1:0] RD;
  logic                  Done;

  modport master (output A, WE, WD, input RD, Done);
  modport slave  (input A, WE, WD, output RD, Done);
endinterface

// File: rtl/fact_accel_top.sv
// Memory-mapped iterative factorial accelerator with overflow detection.
// Optional CYCLES counter at A=4 is built only when FACT_CYCLE_COUNT_EN is defined.
module fact_accel_top #(
  parameter int N_WIDTH    = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              Rst,
  fact_accel_top_if.slave  bus
);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t                state, state_next;
  logic [N_WIDTH-1:0]    n_reg, cnt;
  logic                  go, go_pulse, done, err, ovf;
  logic [DATA_WIDTH-1:0] acc, result;
  logic [PW-1:0]         prod;
  logic                  busy, go_accept, prod_ovf, last_step;
`ifdef FACT_CYCLE_COUNT_EN
  logic [DATA_WIDTH-1:0] cycles;
`endif

  assign busy      = (state != IDLE);
  assign go_accept = bus.WE && (bus.A == 3'd1) && bus.WD[0] && !busy;
  assign prod      = PW'(acc) * PW'(cnt);
  assign prod_ovf  = |prod[PW-1:DATA_WIDTH];
  assign last_step = (cnt <= N_WIDTH'(1));

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go_pulse) state_next = MULT;
      MULT:    if (last_step || prod_ovf) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      n_reg    <= '0;
      go       <= 1'b0;
      go_pulse <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ovf      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
    end else begin
      if (bus.WE && bus.A == 3'd0) n_reg <= bus.WD[N_WIDTH-1:0];
      if (bus.WE && bus.A == 3'd1) go    <= bus.WD[0];
      go_pulse <= go_accept;
      if (go_accept) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        IDLE: if (go_pulse) begin
          acc <= DATA_WIDTH'(1);
          cnt <= n_reg;
        end
        MULT: if (!last_step) begin
          // overflow leaves acc untouched; DONE publishes 0 instead
          if (prod_ovf) ovf <= 1'b1;
          else begin
            acc <= prod[DATA_WIDTH-1:0];
            cnt <= cnt - N_WIDTH'(1);
          end
        end
        DONE: begin
          result <= ovf ? '0 : acc;
          done   <= 1'b1;
          err    <= ovf;
          ovf    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FACT_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)                cycles <= '0;
    else if (go_accept)     cycles <= '0;
    else if (state == MULT) cycles <= cycles + DATA_WIDTH'(1);
  end
`endif

  always_comb begin
    bus.RD = '0;
    case (bus.A)
      3'd0: bus.RD = DATA_WIDTH'(n_reg);
      3'd1: bus.RD = DATA_WIDTH'({busy, go});
      3'd2: bus.RD = DATA_WIDTH'({busy, err, done});
      3'd3: bus.RD = result;
`ifdef FACT_CYCLE_COUNT_EN
      3'd4: bus.RD = cycles;
`endif
      default: bus.RD = '0;
    endcase
  end

  assign bus.Done = done;
endmodule

// File: tb/tb_fact_accel_top.sv
// Self-checking bench for fact_accel_top: timeline-based reference model,
// per-cycle read-back compare, directed scenarios and randomized jobs.
module tb_fact_accel_top;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  fact_accel_top_if #(.DATA_WIDTH(DW)) bus ();

  fact_accel_top #(.N_WIDTH(4), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint unsigned fact(input int unsigned n);
    longint unsigned f = 1;
    for (int unsigned i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  function automatic bit fits(input int unsigned n);
    return fact(n) <= 64'h0000_0000_FFFF_FFFF;
  endfunction

  // clock cycles spent multiplying: n (min 1) normally, or up to the first
  // partial product that no longer fits when overflowing
  function automatic int unsigned job_cycles(input int unsigned n);
    longint unsigned p = 1;
    int unsigned steps = 0;
    if (fits(n)) return (n < 2) ? 1 : n;
    for (int unsigned c = n; c >= 2; c--) begin
      steps++;
      p = p * c;
      if (p > 64'h0000_0000_FFFF_FFFF) return steps;
    end
    return steps;
  endfunction

  logic [3:0]  m_n      = '0;
  logic        m_go     = 1'b0;
  logic        m_done   = 1'b0;
  logic        m_err    = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_cycles = '0;
  logic        m_busy   = 1'b0;
  bit          active   = 1'b0;
  int unsigned t = 0, jc = 0;
  bit          j_err = 1'b0;
  logic [31:0] j_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = '0; m_go = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_result = '0; m_cycles = '0; m_busy = 1'b0; active = 1'b0; t = 0;
    end else begin
      bit accept;
      accept = bus.WE && bus.A == 3'd1 && bus.WD[0] && !m_busy;
      if (bus.WE && bus.A == 3'd0) m_n = bus.WD[3:0];
      if (bus.WE && bus.A == 3'd1) m_go = bus.WD[0];
      if (active) begin
        t++;
        if (t >= 2 && t <= jc + 1) m_cycles = m_cycles + 1;
        if (t == jc + 2) begin
          m_done = 1'b1; m_err = j_err; m_result = j_res; active = 1'b0;
        end
      end
      if (accept) begin
        active = 1'b1; t = 0;
        jc    = job_cycles(m_n);
        j_err = !fits(m_n);
        j_res = j_err ? 32'd0 : 32'(fact(m_n));
        m_done = 1'b0; m_err = 1'b0; m_cycles = '0;
      end
      m_busy = active && t >= 1 && t <= jc + 1;
    end
  end

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_n};
      3'd1: return {30'd0, m_busy, m_go};
      3'd2: return {29'd0, m_busy, m_err, m_done};
      3'd3: return m_result;
`ifdef FACT_CYCLE_COUNT_EN
      3'd4: return m_cycles;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                  name, got, got, exp, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("cycle RD", bus.RD, model_rd(bus.A));
    chk("cycle Done", {31'd0, bus.Done}, {31'd0, m_done});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.A = a; bus.WE = 1'b1; bus.WD = d;
    tick();
    bus.WE = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.A = a;
    #1;
    chk(name, bus.RD, exp);
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound && !bus.Done; i++) tick();
    chk(name, {31'd0, bus.Done}, 32'd1);
  endtask

  task automatic run_job(input logic [3:0] n);
    wr(3'd0, {28'd0, n});
    wr(3'd1, 32'd1);
    wait_done("job done", 40);
  endtask

  initial begin
    bus.A = '0; bus.WE = 1'b0; bus.WD = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: reset while idle, then 5!
    wr(3'd3, 32'hFFFF);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) rd("reset read", 3'(a), 32'd0);
    chk("reset Done", {31'd0, bus.Done}, 32'd0);
    tick();
    rst = 1'b0;
    wr(3'd0, 32'd5);
    wr(3'd1, 32'd1);
    tick();
    rd("n5 busy", 3'd2, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    chk("n5 not yet done", {31'd0, bus.Done}, 32'd0);
    tick();
    chk("n5 Done", {31'd0, bus.Done}, 32'd1);
    rd("n5 result", 3'd3, 32'd120);
    rd("n5 status", 3'd2, 32'd1);
`ifdef FACT_CYCLE_COUNT_EN
    rd("n5 cycles", 3'd4, 32'd5);
`else
    rd("cycles absent", 3'd4, 32'd0);
`endif

    // 2: n=0 and n=1 finish three edges after Go
    for (int n = 0; n < 2; n++) begin
      wr(3'd0, 32'(n));
      wr(3'd1, 32'd1);
      tick(); tick();
      chk("n01 early", {31'd0, bus.Done}, 32'd0);
      tick();
      chk("n01 Done", {31'd0, bus.Done}, 32'd1);
      rd("n01 result", 3'd3, 32'd1);
      rd("n01 status", 3'd2, 32'd1);
`ifdef FACT_CYCLE_COUNT_EN
      rd("n01 cycles", 3'd4, 32'd1);
`endif
    end

    // 3: largest fitting factorial, then overflow
    run_job(4'd12);
    rd("n12 result", 3'd3, 32'd479001600);
    rd("n12 status", 3'd2, 32'd1);
    run_job(4'd13);
    rd("n13 result", 3'd3, 32'd0);
    rd("n13 status", 3'd2, 32'd3);

    // 4: Go and N writes while busy do not restart the job
    wr(3'd0, 32'd10);
    wr(3'd1, 32'd1);
    tick();
    wr(3'd1, 32'd1);
    wr(3'd0, 32'd3);
    wait_done("n10 done", 40);
    rd("n10 result", 3'd3, 32'd3628800);
    rd("n snapshot", 3'd0, 32'd3);
    wr(3'd1, 32'd1);
    wait_done("n3 done", 40);
    rd("n3 result", 3'd3, 32'd6);

    // 5: reset mid-job
    wr(3'd0, 32'd8);
    wr(3'd1, 32'd1);
    tick(); tick(); tick();
    rst = 1'b1;
    rd("rst status", 3'd2, 32'd0);
    rd("rst result", 3'd3, 32'd0);
    tick();
    rst = 1'b0;
    run_job(4'd4);
    rd("n4 result", 3'd3, 32'd24);

    // randomized jobs with bus traffic while busy
    for (int j = 0; j < 30; j++) begin
      bit finished;
      wr(3'd0, 32'($urandom_range(0, 15)));
      wr(3'd1, 32'd1);
      tick();
      finished = 1'b0;
      for (int i = 0; i < 40 && !finished; i++) begin
        if (!m_busy) finished = 1'b1;
        else case ($urandom_range(0, 3))
          0: wr(3'd0, $urandom);
          1: wr(3'd1, $urandom);
          2: wr(3'($urandom_range(2, 7)), $urandom);
          default: begin bus.A = 3'($urandom); tick(); end
        endcase
      end
      chk("random job finished", {31'd0, finished}, 32'd1);
      for (int i = 0; i < 3; i++) begin
        bus.A = 3'($urandom);
        tick();
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
